fft_result_tx: RTL and testbench

Serializes a completed FFT frame out over the SPI slave interface (MISO side). It sits directly downstream of the FFT block. It snapshots all real and imaginary bins on a start pulse, then shifts them out MSB-first, one bit per SPI clock, while `ss` is asserted. It uses the same rise/fall SPI clock pulses the receive path already produces from its edge detectors.

---
 rtl/fft_result_tx.sv | 130 +++++++++++++
 tb/tb_fft_result_tx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_result_tx.sv
// Serializes a captured FFT frame (real/imag interleaved, MSB first) onto the SPI MISO line.
// Shifts on the SPI falling-edge pulse once the master has sampled the current bit.
module fft_result_tx #(
  parameter int NUM_BINS = 128,
  parameter int WORD_W   = 16
) (
  input  logic                                clk,
  input  logic                                n_rst,
  input  logic                                start,
  input  logic [0:NUM_BINS-1][WORD_W-1:0]     outReal,
  input  logic [0:NUM_BINS-1][WORD_W-1:0]     outComplex,
  input  logic                                ss,
  input  logic                                spi_clk_rise,
  input  logic                                spi_clk_fall,
  output logic                                data_out,
  output logic                                busy,
  output logic                                done
);

  localparam int NUM_WORDS = 2 * NUM_BINS;
  localparam int WC_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int BC_W      = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [BC_W-1:0] BIT_MAX   = BC_W'(WORD_W - 1);
  localparam logic [WC_W-1:0] WORD_LAST = WC_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOADED,
    SHIFT,
    DONE
  } state_t;

  state_t            state, state_n;
  logic [BC_W-1:0]   bit_cnt, bit_n;
  logic [WC_W-1:0]   word_cnt, word_n;
  logic              sampled, sampled_n;
  logic              load;
  logic              dout_n;
  logic [WORD_W-1:0] sel_word;

  // Even slots hold real words, odd slots imaginary, matching transmit order.
  logic [WORD_W-1:0] snap [NUM_WORDS];

  always_ff @(posedge clk) begin
    if (load) begin
      for (int b = 0; b < NUM_BINS; b++) begin
        snap[2*b]   <= outReal[b];
        snap[2*b+1] <= outComplex[b];
      end
    end
  end

  always_comb begin
    state_n   = state;
    bit_n     = bit_cnt;
    word_n    = word_cnt;
    sampled_n = sampled;
    load      = 1'b0;
    case (state)
      IDLE: begin
        bit_n     = BIT_MAX;
        word_n    = '0;
        sampled_n = 1'b0;
        if (start) begin
          load    = 1'b1;
          state_n = LOADED;
        end
      end
      LOADED: begin
        bit_n     = BIT_MAX;
        word_n    = '0;
        sampled_n = 1'b0;
        if (!ss) state_n = SHIFT;
      end
      SHIFT: begin
        if (ss) begin
          // Master dropped select mid-frame: rewind so the next select restarts at real[0].
          state_n   = LOADED;
          bit_n     = BIT_MAX;
          word_n    = '0;
          sampled_n = 1'b0;
        end else if (spi_clk_rise) begin
          sampled_n = 1'b1;
          if (word_cnt == WORD_LAST && bit_cnt == '0) state_n = DONE;
        end else if (spi_clk_fall && sampled) begin
          sampled_n = 1'b0;
          if (bit_cnt == '0) begin
            bit_n  = BIT_MAX;
            word_n = word_cnt + WC_W'(1);
          end else begin
            bit_n = bit_cnt - BC_W'(1);
          end
        end
      end
      DONE: begin
        state_n   = IDLE;
        sampled_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  // MISO is registered from the next-cycle pointer so the bit appears the cycle after a shift.
  always_comb begin
    sel_word = snap[word_n];
    dout_n   = 1'b0;
    if (state_n == SHIFT) dout_n = sel_word[bit_n];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      word_cnt <= '0;
      sampled  <= 1'b0;
      data_out <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_n;
      word_cnt <= word_n;
      sampled  <= sampled_n;
      data_out <= dout_n;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_fft_result_tx.sv
// Scoreboard bench for fft_result_tx: stimulus queues expected words, a monitor
// reassembles MISO bits on each rise pulse and compares them word by word.
module tb_fft_result_tx;

  localparam int NUM_BINS  = 128;
  localparam int WORD_W    = 16;
  localparam int NUM_WORDS = 2 * NUM_BINS;
  localparam int NUM_BITS  = NUM_WORDS * WORD_W;

  logic clk = 1'b0;
  logic n_rst, start, ss, rise, fall;
  logic [0:NUM_BINS-1][WORD_W-1:0] out_real, out_imag;
  logic data_out, busy, done;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  logic [WORD_W-1:0] exp_q [$];
  logic              stream_bits [$];
  logic [WORD_W-1:0] acc = '0;
  int                acc_n = 0;

  fft_result_tx #(.NUM_BINS(NUM_BINS), .WORD_W(WORD_W)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start        (start),
    .outReal      (out_real),
    .outComplex   (out_imag),
    .ss           (ss),
    .spi_clk_rise (rise),
    .spi_clk_fall (fall),
    .data_out     (data_out),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: master samples MISO on each rise pulse while selected.
  always @(negedge clk) begin
    logic [WORD_W-1:0] exp_w;
    if (!n_rst || ss) begin
      acc_n = 0;
    end else if (rise) begin
      acc = {acc[WORD_W-2:0], data_out};
      acc_n++;
      stream_bits.push_back(data_out);
      if (acc_n == WORD_W) begin
        acc_n = 0;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got %0h expected none", acc);
        end else begin
          exp_w = exp_q.pop_front();
          chk("stream_word", acc, exp_w);
        end
      end
    end
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spi_bit();
    rise = 1'b1;
    tick();
    rise = 1'b0;
    fall = 1'b1;
    tick();
    fall = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_pattern_a();
    for (int i = 0; i < NUM_BINS; i++) begin
      out_real[i] = 16'(16'h1000 + i);
      out_imag[i] = 16'(16'hA000 + i);
    end
  endtask

  task automatic push_words(input int n);
    for (int w = 0; w < n; w++)
      exp_q.push_back((w % 2) != 0 ? out_imag[w/2] : out_real[w/2]);
  endtask

  // Clocks the remaining bits of a frame and checks the done/busy handoff.
  task automatic finish_frame(input int bits_sent);
    repeat (NUM_BITS - 1 - bits_sent) spi_bit();
    rise = 1'b1;
    tick();
    rise = 1'b0;
    chk("done_after_last_rise", done, 1);
    chk("data_out_in_done", data_out, 0);
    chk("busy_in_done", busy, 1);
    tick();
    chk("busy_after_done", busy, 0);
    chk("done_single_cycle", done, 0);
  endtask

  initial begin
    n_rst = 1'b0; start = 1'b0; ss = 1'b1; rise = 1'b0; fall = 1'b0;
    out_real = '0; out_imag = '0;
    tick(); tick(); tick();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_data_out", data_out, 0);
    n_rst = 1'b1;
    tick();

    // Basic frame with spurious falls and a mid-transfer start carrying new data.
    load_pattern_a();
    push_words(NUM_WORDS);
    done_cnt = 0;
    pulse_start();
    chk("busy_after_start", busy, 1);
    chk("data_out_loaded", data_out, 0);
    ss = 1'b0;
    tick();
    fall = 1'b1; tick(); fall = 1'b0;
    repeat (5) spi_bit();
    rise = 1'b1; fall = 1'b1; tick();
    rise = 1'b0; tick();
    fall = 1'b0;
    fall = 1'b1; tick(); fall = 1'b0;
    repeat (94) spi_bit();
    for (int i = 0; i < NUM_BINS; i++) begin
      out_real[i] = 16'hFFFF;
      out_imag[i] = 16'hFFFF;
    end
    pulse_start();
    chk("busy_during_shift", busy, 1);
    finish_frame(100);
    chk("frame1_done_count", done_cnt, 1);
    chk("frame1_queue_empty", exp_q.size(), 0);

    // Abort after 20 bits, then a full frame from the top.
    load_pattern_a();
    done_cnt = 0;
    pulse_start();
    push_words(1);
    ss = 1'b0;
    tick();
    repeat (20) spi_bit();
    ss = 1'b1;
    tick(); tick();
    chk("abort_busy", busy, 1);
    chk("abort_data_out", data_out, 0);
    chk("abort_no_done", done_cnt, 0);
    push_words(NUM_WORDS);
    ss = 1'b0;
    tick();
    finish_frame(0);
    chk("abort_done_count", done_cnt, 1);
    chk("abort_queue_empty", exp_q.size(), 0);

    // Reset after 37 bits of a frame.
    pulse_start();
    push_words(2);
    ss = 1'b0;
    tick();
    repeat (37) spi_bit();
    n_rst = 1'b0;
    ss = 1'b1;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_data_out", data_out, 0);
    chk("rst_mid_done", done, 0);
    tick(); tick();
    n_rst = 1'b1;
    tick();

    // Restart after reset with a word/bin boundary pattern.
    out_real[0] = 16'h0001;
    out_imag[0] = 16'h8000;
    stream_bits.delete();
    done_cnt = 0;
    push_words(NUM_WORDS);
    pulse_start();
    ss = 1'b0;
    tick();
    finish_frame(0);
    ss = 1'b1;
    chk("boundary_stream_len", stream_bits.size(), NUM_BITS);
    if (stream_bits.size() > 17) begin
      chk("boundary_bit14", stream_bits[14], 0);
      chk("boundary_bit15", stream_bits[15], 1);
      chk("boundary_bit16", stream_bits[16], 1);
      chk("boundary_bit17", stream_bits[17], 0);
    end else begin
      checks++;
      failures++;
      $display("FAIL boundary_stream_short: got %0d expected %0d", stream_bits.size(), NUM_BITS);
    end
    chk("boundary_done_count", done_cnt, 1);
    chk("boundary_queue_empty", exp_q.size(), 0);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
